// File: rtl/func_rom_burst_reader_pkg.sv
// Shared types and helpers for the function ROM burst reader.
// The ROM word for address a is a shifted left, with the vacated low bits
// filled with copies of a's MSB.
package func_rom_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Widths arrive as arguments so one function serves every parameterisation.
  function automatic logic [31:0] rom_word(input logic [31:0] addr,
                                           input int addr_w,
                                           input int data_w);
    logic [31:0] word;
    word = addr << (data_w - addr_w);
    if (addr[addr_w-1]) begin
      word = word | ((32'd1 << (data_w - addr_w)) - 32'd1);
    end
    return word;
  endfunction

  function automatic bit widths_ok(input int addr_w, input int data_w);
    return data_w >= addr_w;
  endfunction

endpackage

// File: rtl/func_rom_burst_reader_if.sv
// Request/response handshake bundle for func_rom_burst_reader.
// rsp_parity exists only when FUNC_ROM_PARITY_EN is defined.
interface func_rom_burst_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 5,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_last;
`ifdef FUNC_ROM_PARITY_EN
  logic              rsp_parity;
`endif

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
`ifdef FUNC_ROM_PARITY_EN
    , input rsp_parity
`endif
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
`ifdef FUNC_ROM_PARITY_EN
    , output rsp_parity
`endif
  );

endinterface

// File: rtl/func_rom_burst_reader_core.sv
// Combinational address-to-word lookup for the function ROM.
module func_rom_core
  import func_rom_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  assign data = DATA_W'(rom_word(32'(addr), ADDR_W, DATA_W));

endmodule

// File: rtl/func_rom_burst_reader.sv
// Function ROM burst reader: single reads or wrapping bursts, one beat per
// cycle, full backpressure on the response side.
// Optional feature macro: FUNC_ROM_PARITY_EN adds registered rsp_parity.
//
//   state | meaning
//   IDLE  | no burst in flight; may accept a request when the output slot frees
//   BURST | loading follow-on beats of an accepted burst; requests refused
module func_rom_burst_reader
  import func_rom_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 5,
  parameter int LEN_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  func_rom_burst_reader_if.slave  bus,
  output logic                    busy
);

  if (!widths_ok(ADDR_W, DATA_W)) begin : g_width_check
    $error("func_rom_burst_reader: DATA_W must be >= ADDR_W");
  end

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              rsp_valid_q;
  logic              rsp_last_q;
  logic [DATA_W-1:0] rsp_data_q;
  // The registered beat address doubles as the burst address pointer.
  logic [ADDR_W-1:0] rsp_addr_q;

  logic              slot_free;
  logic              accept;
  logic              load;
  logic              load_last;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  assign slot_free     = !rsp_valid_q || bus.rsp_ready;
  assign bus.req_ready = (state_q == IDLE) && slot_free;
  assign accept        = bus.req_valid && bus.req_ready;

  func_rom_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .addr (load_addr),
    .data (load_data)
  );

  // State and beat-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Next state and decision whether a beat is loaded into the output slot.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    load        = 1'b0;
    load_last   = 1'b0;
    load_addr   = rsp_addr_q + ADDR_W'(1);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          load_addr = bus.req_addr;
          if (bus.req_len == '0) begin
            load_last = 1'b1;
          end else begin
            state_d     = BURST;
            remaining_d = bus.req_len;
          end
        end
      end
      BURST: begin
        if (slot_free) begin
          load        = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            load_last = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output slot: load a new beat, or empty it after a handshake with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else if (load) begin
      rsp_valid_q <= 1'b1;
      rsp_last_q  <= load_last;
      rsp_data_q  <= load_data;
      rsp_addr_q  <= load_addr;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end
  end

`ifdef FUNC_ROM_PARITY_EN
  logic rsp_parity_q;

  // Parity travels with the data word and stalls with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_parity_q <= 1'b0;
    end else if (load) begin
      rsp_parity_q <= ^load_data;
    end
  end

  assign bus.rsp_parity = rsp_parity_q;
`endif

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign busy          = (state_q != IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_func_rom_burst_reader.sv
// Bench for func_rom_burst_reader: beat-queue model checked every cycle,
// plus literal expectations on directed scenarios.
module tb_func_rom_burst_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  func_rom_burst_reader_if bus ();

  func_rom_burst_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int addr;
    int data;
    bit last;
  } beat_t;

  beat_t q[$];

  // ROM rule for the default widths: word = {a, a[3]}.
  function automatic int model_word(input int a);
    return ((a << 1) | (a >> 3)) & 31;
  endfunction

  function automatic bit odd_ones(input int v);
    int n = 0;
    for (int b = 0; b < 5; b++) n += (v >> b) & 1;
    return n[0];
  endfunction

  // Model: every accepted request enqueues its beats; beats must stream out
  // back to back, so rsp_valid is exactly "queue not empty".
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rsp_data", 32'(bus.rsp_data), 0);
      check("rst_rsp_addr", 32'(bus.rsp_addr), 0);
      check("rst_rsp_last", 32'(bus.rsp_last), 0);
    end else begin
      check("mon_rsp_valid", 32'(bus.rsp_valid), 32'(q.size() > 0));
      check("mon_busy", 32'(busy), 32'(q.size() > 0));
      check("mon_req_ready", 32'(bus.req_ready),
            32'((q.size() == 0) || (q.size() == 1 && bus.rsp_ready)));
      if (q.size() > 0 && bus.rsp_valid) begin
        check("mon_rsp_data", 32'(bus.rsp_data), 32'(q[0].data));
        check("mon_rsp_addr", 32'(bus.rsp_addr), 32'(q[0].addr));
        check("mon_rsp_last", 32'(bus.rsp_last), 32'(q[0].last));
`ifdef FUNC_ROM_PARITY_EN
        check("mon_rsp_parity", 32'(bus.rsp_parity), 32'(odd_ones(q[0].data)));
`endif
        if (bus.rsp_ready) void'(q.pop_front());
      end
      if (bus.req_valid && bus.req_ready) begin
        for (int i = 0; i <= int'(bus.req_len); i++) begin
          beat_t b;
          b.addr = (int'(bus.req_addr) + i) % 16;
          b.data = model_word(b.addr);
          b.last = (i == int'(bus.req_len));
          q.push_back(b);
        end
      end
    end
  end

  // Presents a request and returns 1ns after the accepting edge.
  task automatic send(input int addr, input int len);
    bit ok = 0;
    bus.req_addr  = 4'(addr);
    bus.req_len   = 4'(len);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [4:0] exp1[4];
    int         addr1[4];
    logic [4:0] exp2[4];
    int         addr2[4];
    exp1  = '{5'b00000, 5'b00010, 5'b00100, 5'b11111};
    addr1 = '{0, 1, 2, 15};
    exp2  = '{5'b11101, 5'b11111, 5'b00000, 5'b00010};
    addr2 = '{14, 15, 0, 1};

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready), 1);

    // Single reads.
    for (int i = 0; i < 4; i++) begin
      send(addr1[i], 0);
      @(negedge clk);
      check("single_data", 32'(bus.rsp_data), 32'(exp1[i]));
      check("single_last", 32'(bus.rsp_last), 1);
      check("single_valid", 32'(bus.rsp_valid), 1);
    end
    repeat (2) @(negedge clk);
    check("single_drained", 32'(bus.rsp_valid), 0);

    // Wrapping burst.
    send(14, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("burst_data", 32'(bus.rsp_data), 32'(exp2[i]));
      check("burst_addr", 32'(bus.rsp_addr), 32'(addr2[i]));
      check("burst_last", 32'(bus.rsp_last), 32'(i == 3));
    end
    @(negedge clk);
    check("burst_drained", 32'(bus.rsp_valid), 0);

    // Backpressure on the second beat.
    send(3, 2);
    @(negedge clk);
    check("stall_beat0", 32'(bus.rsp_data), 32'(5'b00110));
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold_data", 32'(bus.rsp_data), 32'(5'b01000));
      check("stall_hold_addr", 32'(bus.rsp_addr), 4);
      check("stall_req_ready", 32'(bus.req_ready), 0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_beat1", 32'(bus.rsp_data), 32'(5'b01000));
    @(negedge clk);
    check("stall_beat2", 32'(bus.rsp_data), 32'(5'b01010));
    check("stall_beat2_last", 32'(bus.rsp_last), 1);
    repeat (2) @(negedge clk);

    // Back-to-back single reads without a bubble.
    bus.req_addr  = 4'd5;
    bus.req_len   = 4'd0;
    bus.req_valid = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.req_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) check("b2b_timeout", 0, 1);
    end
    @(posedge clk);
    #1 bus.req_addr = 4'd6;
    @(negedge clk);
    check("b2b_first", 32'(bus.rsp_data), 32'(5'b01010));
    check("b2b_ready", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_second", 32'(bus.rsp_data), 32'(5'b01100));
    check("b2b_second_valid", 32'(bus.rsp_valid), 1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a burst.
    send(0, 7);
    repeat (3) @(negedge clk);
    check("pre_rst_addr", 32'(bus.rsp_addr), 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_now_valid", 32'(bus.rsp_valid), 0);
    check("rst_now_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(bus.rsp_valid), 0);
    end

`ifdef FUNC_ROM_PARITY_EN
    begin
      int         paddr[3];
      logic [0:0] pexp[3];
      paddr = '{1, 15, 3};
      pexp  = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
        send(paddr[i], 0);
        @(negedge clk);
        check("parity", 32'(bus.rsp_parity), 32'(pexp[i]));
      end
      repeat (2) @(negedge clk);
    end
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
